esc_pulse_transmitter: RTL and testbench



---
 rtl/esc_tx_pkg.sv | 19 +
 rtl/esc_pulse_transmitter_if.sv | 15 +
 rtl/esc_frame_timer.sv | 38 +++
 rtl/esc_pulse_transmitter.sv | 93 +++++++++
 tb/tb_esc_pulse_transmitter.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/esc_tx_pkg.sv
// esc_tx_pkg: state encoding and default timing shared by the ESC pulse transmitter.
package esc_tx_pkg;
    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        RUN      = 2'd2,
        FAILSAFE = 2'd3
    } esc_state_t;
    localparam int DEF_TICKS_PER_US   = 50;
    localparam int DEF_FRAME_US       = 2500;
    localparam int DEF_MIN_US         = 1000;
    localparam int DEF_CMD_MAX        = 1000;
    localparam int DEF_CMD_W          = 11;
    localparam int DEF_ARM_FRAMES     = 400;
    localparam int DEF_TIMEOUT_FRAMES = 40;
    function automatic logic is_armed(esc_state_t s);
        return s == RUN || s == FAILSAFE;
    endfunction
endpackage

// File: rtl/esc_pulse_transmitter_if.sv
// esc_pulse_transmitter_if: command handshake, arm request and pulse/status outputs of one motor channel.
interface esc_pulse_transmitter_if import esc_tx_pkg::*; #(
    parameter int CMD_W = DEF_CMD_W
);
    logic             arm;
    logic [CMD_W-1:0] cmd;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             pwm_out;
    logic             frame_start;
    logic [1:0]       state;
    logic             armed;
    modport master(output arm, cmd, cmd_valid, input cmd_ready, pwm_out, frame_start, state, armed);
    modport slave(input arm, cmd, cmd_valid, output cmd_ready, pwm_out, frame_start, state, armed);
endinterface

// File: rtl/esc_frame_timer.sv
// esc_frame_timer: microsecond prescaler and frame-position counter with boundary/frame-start strobes.
module esc_frame_timer #(
    parameter int TICKS_PER_US = 50,
    parameter int FRAME_US     = 2500,
    parameter int US_W         = $clog2(FRAME_US)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [US_W-1:0] us_count,
    output logic            us_tick,
    output logic            boundary,
    output logic            frame_start
);
    localparam int PS_W = $clog2(TICKS_PER_US + 1);
    logic            live_q;
    logic [PS_W-1:0] psc_q, psc_d;
    logic [US_W-1:0] us_q, us_d;
    // live_q holds the counters for the first cycle after reset so frame 0 starts cleanly
    always_comb begin
        us_tick     = live_q && psc_q == PS_W'(TICKS_PER_US - 1);
        boundary    = us_tick && us_q == US_W'(FRAME_US - 1);
        frame_start = live_q && psc_q == '0 && us_q == '0;
        psc_d       = !live_q ? psc_q : us_tick ? '0 : psc_q + 1'b1;
        us_d        = !us_tick ? us_q : boundary ? '0 : us_q + 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= 1'b0;
            psc_q  <= '0;
            us_q   <= '0;
        end else begin
            live_q <= 1'b1;
            psc_q  <= psc_d;
            us_q   <= us_d;
        end
    end
    assign us_count = us_q;
endmodule

// File: rtl/esc_pulse_transmitter.sv
// esc_pulse_transmitter: frame-periodic ESC pulse generator with double-buffered commands,
// arming sequence and command-timeout failsafe.
module esc_pulse_transmitter import esc_tx_pkg::*; #(
    parameter int TICKS_PER_US   = DEF_TICKS_PER_US,
    parameter int FRAME_US       = DEF_FRAME_US,
    parameter int MIN_US         = DEF_MIN_US,
    parameter int CMD_MAX        = DEF_CMD_MAX,
    parameter int CMD_W          = DEF_CMD_W,
    parameter int ARM_FRAMES     = DEF_ARM_FRAMES,
    parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
    input logic                    clk,
    input logic                    rst,
    esc_pulse_transmitter_if.slave bus
);
    localparam int US_W = $clog2(FRAME_US);
    localparam int WW   = US_W > CMD_W + 1 ? US_W : CMD_W + 1;
    localparam int AC_W = $clog2(ARM_FRAMES + 1);
    localparam int TO_W = $clog2(TIMEOUT_FRAMES + 1);
    esc_state_t       state_q, state_d;
    logic [CMD_W-1:0] shadow_q, shadow_d, active_q, active_d, cmd_sat;
    logic [AC_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             seen_q, seen_d, pwm_q, pwm_d, xfer;
    logic [US_W-1:0]  us_count, us_nxt;
    logic             us_tick, boundary, frame_start;
    logic [WW-1:0]    width_d;
    esc_frame_timer #(.TICKS_PER_US(TICKS_PER_US), .FRAME_US(FRAME_US), .US_W(US_W)) u_timer (
        .clk(clk), .rst(rst), .us_count(us_count), .us_tick(us_tick),
        .boundary(boundary), .frame_start(frame_start)
    );
    // seen_q marks a transfer in the current frame; a boundary-cycle transfer belongs to the next one
    always_comb begin
        xfer      = bus.cmd_valid && is_armed(state_q);
        cmd_sat   = bus.cmd > CMD_W'(CMD_MAX) ? CMD_W'(CMD_MAX) : bus.cmd;
        shadow_d  = state_q == ARMING ? '0 : xfer ? cmd_sat : shadow_q;
        seen_d    = boundary ? xfer : seen_q || xfer;
        active_d  = boundary ? shadow_q : active_q;
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        to_d      = to_q;
        if (boundary && !bus.arm) state_d = DISARMED;
        else if (boundary) begin
            unique case (state_q)
                DISARMED: begin
                    state_d   = ARMING;
                    arm_cnt_d = '0;
                end
                ARMING: begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                    state_d   = arm_cnt_d == AC_W'(ARM_FRAMES) ? RUN : ARMING;
                    to_d      = '0;
                end
                RUN: begin
                    to_d    = seen_q ? '0 : to_q + 1'b1;
                    state_d = to_d == TO_W'(TIMEOUT_FRAMES) ? FAILSAFE : RUN;
                end
                FAILSAFE: begin
                    state_d = seen_q ? RUN : FAILSAFE;
                    to_d    = '0;
                end
            endcase
        end
        // pwm is registered, so it is computed from next-cycle position, state and width
        us_nxt  = boundary ? '0 : us_count + US_W'(us_tick);
        width_d = state_d == RUN ? WW'(MIN_US) + WW'(active_d) : WW'(MIN_US);
        pwm_d   = state_d != DISARMED && WW'(us_nxt) < width_d;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DISARMED;
            shadow_q  <= '0;
            active_q  <= '0;
            arm_cnt_q <= '0;
            to_q      <= '0;
            seen_q    <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            arm_cnt_q <= arm_cnt_d;
            to_q      <= to_d;
            seen_q    <= seen_d;
            pwm_q     <= pwm_d;
        end
    end
    assign bus.cmd_ready   = is_armed(state_q);
    assign bus.armed       = is_armed(state_q);
    assign bus.state       = state_q;
    assign bus.pwm_out     = pwm_q;
    assign bus.frame_start = frame_start;
endmodule

// File: tb/tb_esc_pulse_transmitter.sv
// tb_esc_pulse_transmitter: frame-table, randomized and reset corner-case checks of the ESC transmitter.
module tb_esc_pulse_transmitter;
    localparam int TPU = 2, FUS = 40, MINUS = 10, CMAX = 10, CW = 4, ARMF = 2, TOF = 3;
    localparam int FC = TPU * FUS;
    logic clk = 1'b0;
    logic rst = 1'b1;
    esc_pulse_transmitter_if #(.CMD_W(CW)) bus();
    esc_pulse_transmitter #(
        .TICKS_PER_US(TPU), .FRAME_US(FUS), .MIN_US(MINUS), .CMD_MAX(CMAX),
        .CMD_W(CW), .ARM_FRAMES(ARMF), .TIMEOUT_FRAMES(TOF)
    ) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0, passes = 0, hi_cnt = 0;
    // reference model: cycle position in frame plus the per-frame decisions
    int pos, mst, mw, mshadow, mactive, marm, midle;
    bit mseen;

    typedef struct {
        bit arm;
        int p1;
        int c1;
        int p2;
        int c2;
        int exp_state;
        int exp_high;
    } vec_t;
    vec_t vecs[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_init();
        pos = 0; mst = 0; mw = MINUS * TPU;
        mshadow = 0; mactive = 0; marm = 0; midle = 0; mseen = 0;
    endtask

    task automatic model_step(input bit a, input bit x, input int c);
        int nst, old, sat;
        old = mst;
        sat = c > CMAX ? CMAX : c;
        if (pos == FC - 1) begin
            nst = mst;
            if (!a) nst = 0;
            else if (mst == 0) begin nst = 1; marm = 0; end
            else if (mst == 1) begin marm++; if (marm == ARMF) begin nst = 2; midle = 0; end end
            else if (mst == 2) begin midle = mseen ? 0 : midle + 1; if (midle == TOF) nst = 3; end
            else if (mseen) begin nst = 2; midle = 0; end
            mactive = mshadow;
            mst = nst;
            mseen = x;
            pos = 0;
        end else begin
            mseen = mseen | x;
            pos++;
        end
        if (x) mshadow = sat;
        if (old == 1) mshadow = 0;
        mw = (mst == 2 ? MINUS + mactive : MINUS) * TPU;
    endtask

    task automatic cycle(input bit a, input bit v, input int c);
        chk("pwm_out", bus.pwm_out, (mst != 0 && pos < mw) ? 1 : 0);
        chk("frame_start", bus.frame_start, pos == 0);
        chk("state", bus.state, mst);
        chk("armed", bus.armed, mst >= 2);
        chk("cmd_ready", bus.cmd_ready, mst >= 2);
        hi_cnt += bus.pwm_out;
        bus.arm = a;
        bus.cmd_valid = v;
        bus.cmd = 4'(c);
        model_step(a, v && mst >= 2, c);
        @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_pwm"}, bus.pwm_out, 0);
        chk({tag, "_fs"}, bus.frame_start, 0);
        chk({tag, "_state"}, bus.state, 0);
        chk({tag, "_armed"}, bus.armed, 0);
        chk({tag, "_ready"}, bus.cmd_ready, 0);
    endtask

    initial begin
        bit ra;
        int guard;
        vecs[0]  = '{1'b0, -1, 0, -1, 0, 0, 0};
        vecs[1]  = '{1'b0, -1, 0, -1, 0, 0, 0};
        vecs[2]  = '{1'b0, -1, 0, -1, 0, 0, 0};
        vecs[3]  = '{1'b1, -1, 0, -1, 0, 0, 0};
        vecs[4]  = '{1'b1, -1, 0, -1, 0, 1, 20};
        vecs[5]  = '{1'b1, -1, 0, -1, 0, 1, 20};
        vecs[6]  = '{1'b1, 40, 5, -1, 0, 2, 20};
        vecs[7]  = '{1'b1, 40, 15, -1, 0, 2, 30};
        vecs[8]  = '{1'b1, 20, 3, 60, 7, 2, 40};
        vecs[9]  = '{1'b1, -1, 0, -1, 0, 2, 34};
        vecs[10] = '{1'b1, -1, 0, -1, 0, 2, 34};
        vecs[11] = '{1'b1, -1, 0, -1, 0, 2, 34};
        vecs[12] = '{1'b1, 20, 4, -1, 0, 3, 20};
        vecs[13] = '{1'b1, 79, 2, -1, 0, 2, 28};
        vecs[14] = '{1'b1, -1, 0, -1, 0, 2, 28};
        vecs[15] = '{1'b0, -1, 0, -1, 0, 2, 24};
        vecs[16] = '{1'b0, -1, 0, -1, 0, 0, 0};
        bus.arm = 1'b1; bus.cmd_valid = 1'b0; bus.cmd = '0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        bus.arm = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        model_init();
        for (int i = 0; i < 17; i++) begin
            int st;
            hi_cnt = 0;
            st = bus.state;
            for (int p = 0; p < FC; p++)
                cycle(vecs[i].arm, p == vecs[i].p1 || p == vecs[i].p2,
                      p == vecs[i].p2 ? vecs[i].c2 : vecs[i].c1);
            chk($sformatf("vec%0d_state", i), st, vecs[i].exp_state);
            chk($sformatf("vec%0d_high", i), hi_cnt, vecs[i].exp_high);
        end
        ra = 1'b1;
        for (int n = 0; n < 60 * FC; n++) begin
            if ($urandom_range(0, 1999) == 0) ra = !ra;
            cycle(ra, $urandom_range(0, 99) == 0, int'($urandom_range(0, 15)));
        end
        guard = 0;
        while (!(mst != 0 && pos == 10) && guard < 4 * FC) begin
            cycle(1'b1, 1'b0, 0);
            guard++;
        end
        chk("reach_pulse", guard < 4 * FC, 1);
        chk("pwm_before_rst", bus.pwm_out, 1);
        #1 rst = 1'b1;
        #1 reset_checks("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_init();
        for (int n = 0; n < 3 * FC; n++) cycle(1'b1, 1'b0, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
